// File: rtl/metronome_rx.sv
// metronome_rx: receive side of the metronome beat generator.
// Measures spacing between beat strobes, tracks lock against PERIOD,
// and queues beat data in a small FIFO drained over a valid/ready port.
module metronome_rx #(
  parameter int PERIOD = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_valid,
  input  logic [DATA_W-1:0] beat_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              locked,
  output logic              period_err,
  output logic              stream_end,
  output logic              overflow,
  output logic [7:0]        beat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] GAP_OK  = 8'(PERIOD);
  localparam logic [7:0] GAP_TMO = 8'(2 * PERIOD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        icnt_q, icnt_d;
  logic [1:0]        match_q, match_d;
  logic              locked_q, locked_d;
  logic              period_err_q, period_err_d;
  logic              stream_end_q, stream_end_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        beat_count_q, beat_count_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic gap_ok;
  logic timeout;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // icnt holds the gap to the previous beat at the moment a new beat arrives
  assign gap_ok  = (icnt_q == GAP_OK);
  assign timeout = !beat_valid && (state_q != IDLE) && (icnt_q == GAP_TMO);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop  = !fifo_empty && out_ready;
  assign push = beat_valid && (!fifo_full || pop);

  // out_data is forced to zero while empty so that reset clears every output
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign locked     = locked_q;
  assign period_err = period_err_q;
  assign stream_end = stream_end_q;
  assign overflow   = overflow_q;
  assign beat_count = beat_count_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state and match counter
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    unique case (state_q)
      IDLE: begin
        if (beat_valid) begin
          state_d = ACQ;
          match_d = '0;
        end
      end
      ACQ: begin
        if (beat_valid) begin
          if (gap_ok) begin
            match_d = match_q + 2'd1;
            if (match_d == 2'd2) state_d = LOCK;
          end else begin
            match_d = '0;
          end
        end else if (timeout) begin
          state_d = IDLE;
          match_d = '0;
        end
      end
      LOCK: begin
        if (beat_valid) begin
          if (!gap_ok) begin
            state_d = ACQ;
            match_d = '0;
          end
        end else if (timeout) begin
          state_d = IDLE;
          match_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        match_d = '0;
      end
    endcase
  end

  // FSM outputs, registered one cycle after the deciding beat or timeout
  always_comb begin
    locked_d     = (state_d == LOCK);
    period_err_d = (state_q == LOCK) && beat_valid && !gap_ok;
    stream_end_d = timeout;
  end

  // interval counter, beat counter, FIFO pointers and overflow flag
  always_comb begin
    icnt_d       = icnt_q;
    beat_count_d = beat_count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    mem_d        = mem_q;
    if (beat_valid) begin
      icnt_d       = 8'd1;
      beat_count_d = beat_count_q + 8'd1;
    end else if (icnt_q != 8'hFF) begin
      icnt_d = icnt_q + 8'd1;
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = beat_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (beat_valid && !push) overflow_d = 1'b1;
  end

  // control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt_q       <= '0;
      match_q      <= '0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      stream_end_q <= 1'b0;
      overflow_q   <= 1'b0;
      beat_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      icnt_q       <= icnt_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
      period_err_q <= period_err_d;
      stream_end_q <= stream_end_d;
      overflow_q   <= overflow_d;
      beat_count_q <= beat_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_metronome_rx.sv
// Testbench for metronome_rx: directed scenarios followed by random beat
// streams, all compared every cycle against a queue-based reference model.
module tb_metronome_rx;

  localparam int P  = 8;
  localparam int DW = 16;
  localparam int D  = 4;

  localparam int S_IDLE = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          beat_valid = 1'b0;
  logic [DW-1:0] beat_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          locked;
  logic          period_err;
  logic          stream_end;
  logic          overflow;
  logic [7:0]    beat_count;

  metronome_rx #(
    .PERIOD(P),
    .DATA_W(DW),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .beat_valid(beat_valid),
    .beat_data (beat_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .locked    (locked),
    .period_err(period_err),
    .stream_end(stream_end),
    .overflow  (overflow),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // reference model state
  int            m_since;
  int            m_state;
  int            m_run;
  bit            m_locked;
  bit            m_perr;
  bit            m_send;
  bit            m_ovf;
  int            m_cnt;
  logic [DW-1:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  function automatic void model_reset();
    m_since  = 0;
    m_state  = S_IDLE;
    m_run    = 0;
    m_locked = 1'b0;
    m_perr   = 1'b0;
    m_send   = 1'b0;
    m_ovf    = 1'b0;
    m_cnt    = 0;
    m_q.delete();
  endfunction

  // one clock edge of the receiver, given the inputs presented before it
  function automatic void model_step(input bit b, input logic [DW-1:0] d, input bit r);
    int gap = m_since;
    bit pop;
    m_perr = 1'b0;
    m_send = 1'b0;
    if (b) begin
      if (m_state == S_IDLE) begin
        m_state = S_ACQ;
        m_run   = 0;
      end else if (m_state == S_ACQ) begin
        if (gap == P) begin
          m_run++;
          if (m_run == 2) m_state = S_LOCK;
        end else begin
          m_run = 0;
        end
      end else if (gap != P) begin
        m_perr  = 1'b1;
        m_state = S_ACQ;
        m_run   = 0;
      end
    end else if (m_state != S_IDLE && gap == 2 * P) begin
      m_state = S_IDLE;
      m_run   = 0;
      m_send  = 1'b1;
    end
    m_locked = (m_state == S_LOCK);
    m_since  = b ? 1 : ((m_since < 255) ? m_since + 1 : 255);
    if (b) m_cnt = (m_cnt + 1) % 256;
    pop = (m_q.size() > 0) && r;
    if (pop) void'(m_q.pop_front());
    if (b) begin
      if (m_q.size() < D) m_q.push_back(d);
      else                m_ovf = 1'b1;
    end
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("period_err", 32'(period_err), 32'(m_perr));
    chk("stream_end", 32'(stream_end), 32'(m_send));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("beat_count", 32'(beat_count), 32'(m_cnt));
  endtask

  task automatic step(input bit b, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    beat_valid = b;
    beat_data  = d;
    out_ready  = r;
    model_step(b, d, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // gap-1 idle cycles then a beat, so the beat lands exactly gap edges later
  task automatic beat_after(input int gap, input logic [DW-1:0] d, input bit r);
    for (int i = 1; i < gap; i++) step(1'b0, DW'($urandom), r);
    step(1'b1, d, r);
  endtask

  task automatic do_reset();
    #2;
    rst        = 1'b0;
    beat_valid = 1'b0;
    out_ready  = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_period_err", 32'(period_err), 32'd0);
    chk("rst_stream_end", 32'(stream_end), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_step(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;

    do_reset();

    // acquire lock on a clean 8-cycle stream
    step(1'b1, 16'h0001, 1'b1);
    chk("word1_next_cycle", 32'(out_data), 32'h0001);
    beat_after(P, 16'h0002, 1'b1);
    chk("no_lock_after_2nd", 32'(locked), 32'd0);
    beat_after(P, 16'h0003, 1'b1);
    chk("lock_after_3rd", 32'(locked), 32'd1);
    chk("word3_next_cycle", 32'(out_data), 32'h0003);
    beat_after(P, 16'h0004, 1'b1);
    beat_after(P, 16'h0005, 1'b1);

    // short gap while locked
    beat_after(6, 16'h0006, 1'b1);
    chk("perr_pulse", 32'(period_err), 32'd1);
    chk("unlock_on_err", 32'(locked), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("perr_one_cycle", 32'(period_err), 32'd0);
    beat_after(P - 1, 16'h0007, 1'b1);
    beat_after(P, 16'h0008, 1'b1);
    chk("relock", 32'(locked), 32'd1);

    // beats stop: timeout at icnt == 2*PERIOD
    for (int i = 1; i < 2 * P; i++) step(1'b0, '0, 1'b1);
    chk("no_early_end", 32'(stream_end), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("stream_end_pulse", 32'(stream_end), 32'd1);
    chk("unlock_timeout", 32'(locked), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("stream_end_one_cycle", 32'(stream_end), 32'd0);
    step(1'b1, 16'h0009, 1'b1);
    beat_after(P, 16'h000A, 1'b1);
    beat_after(P, 16'h000B, 1'b1);
    chk("relock_after_idle", 32'(locked), 32'd1);

    // full FIFO with a beat coinciding with a pop
    step(1'b0, '0, 1'b1);
    beat_after(P - 1, 16'h00B0, 1'b0);
    beat_after(P, 16'h00B1, 1'b0);
    beat_after(P, 16'h00B2, 1'b0);
    beat_after(P, 16'h00B3, 1'b0);
    for (int i = 1; i < P; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 16'h00B4, 1'b1);
    chk("full_pop_no_ovf", 32'(overflow), 32'd0);
    chk("full_pop_head", 32'(out_data), 32'h00B1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) got++;
      step(1'b0, '0, 1'b1);
    end
    chk("full_pop_occupancy", 32'(got), 32'd4);

    // overflow with a stalled consumer
    do_reset();
    step(1'b1, 16'h00A0, 1'b0);
    for (int k = 1; k < 6; k++) beat_after(P, DW'(16'h00A0 + k), 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_beat_count", 32'(beat_count), 32'd6);
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", 32'(out_data), 32'(16'h00A0 + k));
      step(1'b0, '0, 1'b1);
    end
    chk("drained_empty", 32'(out_valid), 32'd0);
    chk("ovf_still_sticky", 32'(overflow), 32'd1);

    // reset mid-stream while locked with two words queued
    do_reset();
    step(1'b1, 16'h00C0, 1'b1);
    for (int i = 1; i < P; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 16'h00C1, 1'b0);
    for (int i = 1; i < P; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 16'h00C2, 1'b0);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();
    step(1'b1, 16'h00D0, 1'b1);
    chk("count_restart", 32'(beat_count), 32'd1);
    chk("no_lock_after_rst", 32'(locked), 32'd0);
    beat_after(P, 16'h00D1, 1'b1);
    beat_after(P, 16'h00D2, 1'b1);
    chk("reacquire", 32'(locked), 32'd1);

    // random beat streams with jittered gaps and a bursty consumer
    do_reset();
    for (int n = 0; n < 50; n++) begin
      int g;
      int bias;
      g    = ($urandom_range(0, 9) < 7) ? P : int'($urandom_range(1, 2 * P + 4));
      bias = int'($urandom_range(0, 3));
      for (int i = 1; i < g; i++)
        step(1'b0, DW'($urandom), int'($urandom_range(0, 3)) < bias + 1);
      step(1'b1, DW'($urandom), int'($urandom_range(0, 3)) < bias + 1);
    end
    for (int i = 0; i < 3 * P; i++) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/metronome_rx.md
Name: metronome_rx

Overview:
- Receive-side counterpart of the metronome beat generator in the PE datapath.
- Samples the periodic data_out_valid strobe and its data word, checks beat spacing against the expected period, and tracks lock.
- Buffers each beat's data in a small FIFO and drains it through a valid/ready port to the downstream PE stage.

Parameters:
PERIOD, 8, expected clk cycles between consecutive beats; legal range 2..127.
DATA_W, 16, width of beat data word.
DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
clk  input  1  clock, all logic on posedge.
rst  input  1  asynchronous reset, active-low.
beat_valid  input  1  single-cycle beat strobe (metronome data_out_valid).
beat_data  input  DATA_W  data qualified by beat_valid.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  DATA_W  FIFO head word.
locked  output  1  beat spacing stable at PERIOD.
period_err  output  1  one-cycle pulse: beat arrived off-period while locked.
stream_end  output  1  one-cycle pulse: beats stopped (timeout).
overflow  output  1  sticky: a beat was dropped on a full FIFO.
beat_count  output  8  received beats, wraps 255->0.

Behaviour:
- Reset (rst=0, async): state=IDLE, icnt=0, match=0, FIFO empty, every output 0.
- Interval counter icnt, 8-bit:
  - On beat_valid: icnt<=1.
  - Otherwise: icnt<=icnt+1, saturating at 255.
  - At a beat, gap=icnt. Beats at cycles t and t+PERIOD give gap=PERIOD.
- FSM states IDLE, ACQ, LOCK:
  - IDLE: on beat -> ACQ, match<=0.
  - ACQ:
    - Beat with gap==PERIOD: match<=match+1. When the new match reaches 2 -> LOCK, locked<=1 on the following cycle.
    - Beat with gap!=PERIOD: match<=0, stay in ACQ.
  - LOCK:
    - Beat with gap==PERIOD: stay in LOCK.
    - Beat with gap!=PERIOD: period_err=1 for one cycle, locked<=0, -> ACQ, match<=0.
  - Timeout: in ACQ or LOCK, when icnt==2*PERIOD with no beat that cycle -> IDLE, locked<=0, match<=0, stream_end=1 for one cycle. No timeout in IDLE.
  - A beat on the same cycle as the timeout threshold counts as a beat, not a timeout. Its gap is 2*PERIOD, so it is off-period.
- beat_count increments on every beat_valid, including dropped beats.
- FIFO:
  - Push beat_data on beat_valid.
  - Pop when out_valid && out_ready.
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the word is dropped and overflow<=1, sticky until reset.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Latency: a beat at cycle t gives out_valid=1 at t+1 when the FIFO was empty. out_data is stable while out_valid=1 and out_ready=0.
  - Pointers are log2(DEPTH)+1 bits. full/empty are derived from the MSB compare.
- Reset asserted mid-stream discards FIFO contents and lock. No output glitches past the reset edge.
- All outputs are registered except out_valid and out_data, which come directly from FIFO state and memory.

Test Plan:
- Beats every 8 cycles with data 0x0001,0x0002,... and out_ready=1 -> locked rises one cycle after the 3rd beat; out_data sequence 1,2,3,...; each word appears one cycle after its beat; period_err never pulses.
- While locked, one beat at gap 6 -> period_err high exactly one cycle, locked falls; two further 8-cycle gaps -> locked=1 again.
- While locked, beats stop -> stream_end pulses when icnt==16 after the last beat; state IDLE, locked=0; the next beat re-enters ACQ.
- out_ready=0, 6 beats with data 0xA0..0xA5, DEPTH=4 -> FIFO holds A0..A3, overflow=1, beat_count=6. Then out_ready=1 -> drains A0,A1,A2,A3, then out_valid=0.
- FIFO full, beat coincides with a pop -> word accepted, no overflow, count stays 4.
- rst pulsed low mid-stream, locked with 2 words queued -> outputs all 0 immediately; after release the FSM reacquires from IDLE and beat_count restarts from 0.
